serv_decode_q: RTL
==================

// Module: serv_decode_q
// PURPOSE
//  Parametrised instruction-queue decoder; successor to the single-register SERV decoder.
//  Buffers up to DEPTH fetched instruction words in a circular queue between ibus and core state.
//  Decodes the head entry into control flags.
//  Sits between the ibus response (i_wb_rdt/i_wb_en) and serv_state/serv_ctrl, so the next fetch overlaps execution.
// PARAMETERS
//  DEPTH  2  queue entries; power of two, >=1
//  AW     $clog2(DEPTH)>0 ? $clog2(DEPTH) : 1  pointer width (derived; do not override)
// PORTS
//  clk             in   1   clock
//  i_rst           in   1   synchronous active-high reset
//  i_wb_rdt        in   30  instruction bits [31:2]
//  i_wb_en         in   1   push i_wb_rdt into queue
//  i_dec_next      in   1   pop head (core retired current instruction)
//  i_flush         in   1   discard all queued entries (taken branch/trap)
//  o_full          out  1   queue holds DEPTH entries
//  o_dec_valid     out  1   head entry valid
//  o_ovf           out  1   sticky: push dropped while full
//  o_rd_op         out  1   instruction writes rd
//  o_two_stage_op  out  1   two-stage op (mem, shift, slt, branch)
//  o_branch_op     out  1   branch/jal/jalr/system
//  o_shift_op      out  1   shift op
//  o_dbus_en       out  1   load/store
//  o_mem_cmd       out  1   1=store
//  o_csr_op        out  1   CSR access
//  o_e_op          out  1   ecall/ebreak
//  o_ctrl_mret     out  1   mret
//  o_ctrl_dret     out  1   dret (0 unless SERV_DECODE_DRET_EN)
// BEHAVIOUR
//  Reset: rd/wr pointers 0, count 0, o_full=0, o_dec_valid=0, o_ovf=0, all decode outputs 0.
//  Storage: DEPTH x 30-bit regs, wr_ptr/rd_ptr AW bits wrapping modulo DEPTH; count 0..DEPTH.
//  Push accepted iff i_wb_en & (!o_full | i_dec_next). Push when full without pop: word dropped, o_ovf<=1.
//  o_ovf holds until i_rst; i_flush does not clear it.
//  Pop accepted iff i_dec_next & o_dec_valid; pop on empty is ignored, no state change.
//  Push+pop in the same cycle: count unchanged, both pointers advance; legal at full and at count=1.
//  Push+pop into an empty queue: pop is ignored and the push is stored.
//  Latency: a push into an empty queue gives o_dec_valid=1 and valid decode on the next cycle.
//  No same-cycle bypass.
//  i_flush: count<=0, rd_ptr<=wr_ptr, and it overrides a coincident pop.
//  A coincident push is kept as the sole entry: count<=1, rd_ptr<=wr_ptr, wr_ptr<=wr_ptr+1.
//  o_full = (count==DEPTH); o_dec_valid = (count!=0).
//  Decode is combinational from the head entry w = mem[rd_ptr].
//  All decode outputs are forced to 0 while o_dec_valid=0.
//  Decode terms: op=w[6:2], f3=w[14:12], sys=op[4]&op[2], f0=(f3==0).
//   rd_op      = op[2] | op[4]&op[0] | !op[3]&!op[0]
//   two_stage  = !op[2] | (f3[0]&!f3[1]&!op[0]&!op[4]) | (f3[1]&!f3[2]&!op[0]&!op[4])
//   branch_op  = op[4];  shift_op = op[2]&!f3[1]
//   dbus_en    = !op[2]&!op[4];  mem_cmd = op[3]
//   csr_op     = sys&!f0;  e_op = sys&f0&!w[21];  mret = sys&f0&w[21] (see CONFIGURATION)
//  Reset mid-operation discards all entries. A push coincident with i_rst is dropped.
// CONFIGURATION
//  SERV_DECODE_DRET_EN defined:
//   o_ctrl_dret = sys&f0&w[21]&w[30]; o_ctrl_mret = sys&f0&w[21]&!w[30].
//  Not defined: o_ctrl_dret tied 0; o_ctrl_mret = sys&f0&w[21], so dret decodes as mret.
// TESTING
//  T1 reset, push lw 0x00012083 ->
//     next cycle: o_dec_valid=1, rd_op=1, dbus_en=1, two_stage=1, mem_cmd=0.
//  T2 push sw 0x00112023, pop previous ->
//     rd_op=0, mem_cmd=1, dbus_en=1, o_dec_valid stays 1.
//  T3 DEPTH=2, push 0x00000013, 0x00100093, 0x00200113 with no pop ->
//     o_full=1 after 2nd push, o_ovf=1, third word never decoded; pops return addi x0 then addi x1.
//  T4 full, push+pop same cycle for 8 cycles with incrementing words ->
//     order preserved across pointer wrap, o_full stays 1, o_ovf unchanged.
//  T5 2 entries queued, i_flush with push 0x30200073 ->
//     next cycle: count=1, o_ctrl_mret=1, o_e_op=0.
//  T6 push 0x7b200073 ->
//     with SERV_DECODE_DRET_EN: o_ctrl_dret=1, o_ctrl_mret=0;
//     without: o_ctrl_mret=1, o_ctrl_dret=0.

Source files
------------

// File: rtl/serv_decode_q_if.sv
// serv_decode_q_if
//   Groups the instruction-queue decoder's bus signals.
//   master: the fetch/core side. It drives the ibus response, pop and flush,
//   and it receives the queue status and the decoded flags.
//   slave: the decoder, serv_decode_q.
//   Signals:
//     i_wb_rdt[29:0]  instruction bits [31:2]
//     i_wb_en         push i_wb_rdt into the queue
//     i_dec_next      pop the head entry
//     i_flush         discard all queued entries
//     o_full, o_dec_valid, o_ovf                           queue status
//     o_rd_op .. o_ctrl_dret                               decoded head flags
interface serv_decode_q_if;
  logic [29:0] i_wb_rdt;
  logic        i_wb_en;
  logic        i_dec_next;
  logic        i_flush;
  logic        o_full;
  logic        o_dec_valid;
  logic        o_ovf;
  logic        o_rd_op;
  logic        o_two_stage_op;
  logic        o_branch_op;
  logic        o_shift_op;
  logic        o_dbus_en;
  logic        o_mem_cmd;
  logic        o_csr_op;
  logic        o_e_op;
  logic        o_ctrl_mret;
  logic        o_ctrl_dret;

  modport master (
    output i_wb_rdt, i_wb_en, i_dec_next, i_flush,
    input  o_full, o_dec_valid, o_ovf, o_rd_op, o_two_stage_op, o_branch_op,
           o_shift_op, o_dbus_en, o_mem_cmd, o_csr_op, o_e_op, o_ctrl_mret,
           o_ctrl_dret
  );

  modport slave (
    input  i_wb_rdt, i_wb_en, i_dec_next, i_flush,
    output o_full, o_dec_valid, o_ovf, o_rd_op, o_two_stage_op, o_branch_op,
           o_shift_op, o_dbus_en, o_mem_cmd, o_csr_op, o_e_op, o_ctrl_mret,
           o_ctrl_dret
  );
endinterface

// File: rtl/serv_decode_q.sv
// serv_decode_q
//   Instruction-queue decoder. It holds up to DEPTH fetched instruction
//   words in a circular queue, so the next fetch can overlap execution.
//   It decodes the head entry into SERV control flags.
//   Ports:
//     clk    clock
//     i_rst  synchronous active-high reset
//     bus    serv_decode_q_if.slave (ibus push, pop, flush, status, flags)
//   Parameters:
//     DEPTH  queue entries, a power of two >= 1
//     AW     pointer width (derived, do not override)
//   Optional feature:
//     SERV_DECODE_DRET_EN  when defined, dret decodes to o_ctrl_dret.
//                          When undefined, o_ctrl_dret is 0 and dret
//                          decodes as mret.
module serv_decode_q #(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH) > 0 ? $clog2(DEPTH) : 1
) (
  input logic         clk,
  input logic         i_rst,
  serv_decode_q_if.slave bus
);

  localparam int CW = AW + 1;

  logic [29:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full;
  logic          valid;
  logic          accept;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + AW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);

  // A flush empties the queue, so a coincident push always has room.
  assign accept = bus.i_wb_en & (bus.i_flush | ~full | bus.i_dec_next);
  // A pop needs a valid head. A flush overrides it.
  assign pop    = bus.i_dec_next & valid & ~bus.i_flush;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (bus.i_flush) begin
        // A surviving push lands at wr_ptr, which becomes the new head.
        rd_ptr <= wr_ptr;
        count  <= accept ? CW'(1) : '0;
      end else begin
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(accept) - CW'(pop);
      end
      if (bus.i_wb_en & ~accept) ovf <= 1'b1;
    end
  end

  // Storage is data only. Stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (!i_rst && accept) mem[wr_ptr] <= bus.i_wb_rdt;
  end

  // ---- decode of the head entry (instruction bit n is stored at n-2) ----
  logic [4:0] op;
  logic [2:0] f3;
  logic       imm1;
  logic       sys;
  logic       f0;
  logic       mret_dec;
  logic       dret_dec;

  assign op   = mem[rd_ptr][4:0];
  assign f3   = mem[rd_ptr][12:10];
  assign imm1 = mem[rd_ptr][19];
  assign sys  = op[4] & op[2];
  assign f0   = (f3 == 3'b000);

`ifdef SERV_DECODE_DRET_EN
  // Instruction bit 30 separates dret (0x7b2) from mret (0x302).
  assign dret_dec = sys & f0 & imm1 & mem[rd_ptr][28];
  assign mret_dec = sys & f0 & imm1 & ~mem[rd_ptr][28];
`else
  assign dret_dec = 1'b0;
  assign mret_dec = sys & f0 & imm1;
`endif

  assign bus.o_full         = full;
  assign bus.o_dec_valid    = valid;
  assign bus.o_ovf          = ovf;
  assign bus.o_rd_op        = valid & (op[2] | (op[4] & op[0]) | (~op[3] & ~op[0]));
  assign bus.o_two_stage_op = valid & (~op[2]
                              | (f3[0] & ~f3[1] & ~op[0] & ~op[4])
                              | (f3[1] & ~f3[2] & ~op[0] & ~op[4]));
  assign bus.o_branch_op    = valid & op[4];
  assign bus.o_shift_op     = valid & op[2] & ~f3[1];
  assign bus.o_dbus_en      = valid & ~op[2] & ~op[4];
  assign bus.o_mem_cmd      = valid & op[3];
  assign bus.o_csr_op       = valid & sys & ~f0;
  assign bus.o_e_op         = valid & sys & f0 & ~imm1;
  assign bus.o_ctrl_mret    = valid & mret_dec;
  assign bus.o_ctrl_dret    = valid & dret_dec;

endmodule
